// File: rtl/tlb_pkg.sv
// Shared types and constants for the multi-port LoongArch TLB.
package tlb_pkg;

   localparam int unsigned VPPN_W = 19;
   localparam int unsigned ASID_W = 10;
   localparam int unsigned PPN_W  = 20;
   localparam int unsigned PS_W   = 6;
   localparam int unsigned PLV_W  = 2;
   localparam int unsigned MAT_W  = 2;

   localparam logic [PS_W-1:0] PS_4KB = 6'h0c;
   localparam logic [PS_W-1:0] PS_4MB = 6'h16;

   localparam logic [4:0] INV_ALL0    = 5'd0;
   localparam logic [4:0] INV_ALL1    = 5'd1;
   localparam logic [4:0] INV_GLB     = 5'd2;
   localparam logic [4:0] INV_NGLB    = 5'd3;
   localparam logic [4:0] INV_ASID    = 5'd4;
   localparam logic [4:0] INV_ASID_VA = 5'd5;
   localparam logic [4:0] INV_GA_VA   = 5'd6;

   typedef struct packed {
      logic [PPN_W-1:0] ppn;
      logic [PLV_W-1:0] plv;
      logic [MAT_W-1:0] mat;
      logic             d;
      logic             v;
   } tlb_page_t;

   // E is held separately so it alone can be reset.
   typedef struct packed {
      logic [VPPN_W-1:0] vppn;
      logic              ps4mb;
      logic [ASID_W-1:0] asid;
      logic              g;
      tlb_page_t [1:0]   pg;
   } tlb_entry_t;

   function automatic logic va_hit(input logic [VPPN_W-1:0] ent_vppn, input logic ps4mb,
                                   input logic [VPPN_W-1:0] vppn);
      return (ent_vppn[18:10] == vppn[18:10]) && (ps4mb || (ent_vppn[9:0] == vppn[9:0]));
   endfunction

endpackage

// File: rtl/tlb_match_cell.sv
// One entry against one search port: valid, VA (page-size aware), ASID/global compare.
module tlb_match_cell
   import tlb_pkg::*;
(
   input  logic              e,
   input  logic [VPPN_W-1:0] ent_vppn,
   input  logic              ps4mb,
   input  logic [ASID_W-1:0] ent_asid,
   input  logic              g,
   input  logic [VPPN_W-1:0] vppn,
   input  logic [ASID_W-1:0] asid,
   output logic              hit
);

   assign hit = e & va_hit(ent_vppn, ps4mb, vppn) & (g | (ent_asid == asid));

endmodule

// File: rtl/tlb_mport.sv
// Fully-associative TLB with NSPORT registered search ports, registered read port,
// round-robin fill pointer and invtlb.
module tlb_mport
   import tlb_pkg::*;
#(
   parameter  int unsigned TLBNUM = 32,
   parameter  int unsigned NSPORT = 2,
   localparam int unsigned IW     = $clog2(TLBNUM)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NSPORT-1:0]        s_req,
   input  logic [NSPORT*VPPN_W-1:0] s_vppn,
   input  logic [NSPORT*ASID_W-1:0] s_asid,
   input  logic [NSPORT-1:0]        s_va_bit12,
   output logic [NSPORT-1:0]        s_valid,
   output logic [NSPORT-1:0]        s_found,
   output logic [NSPORT-1:0]        s_multi,
   output logic [NSPORT*IW-1:0]     s_index,
   output logic [NSPORT*PPN_W-1:0]  s_ppn,
   output logic [NSPORT*PS_W-1:0]   s_ps,
   output logic [NSPORT*PLV_W-1:0]  s_plv,
   output logic [NSPORT*MAT_W-1:0]  s_mat,
   output logic [NSPORT-1:0]        s_d,
   output logic [NSPORT-1:0]        s_v,
   input  logic                     inv_valid,
   input  logic [4:0]               inv_op,
   input  logic [ASID_W-1:0]        inv_asid,
   input  logic [VPPN_W-1:0]        inv_vppn,
   output logic                     inv_err,
   input  logic                     we,
   input  logic                     w_fill,
   input  logic [IW-1:0]            w_index,
   input  logic                     w_e,
   input  logic [VPPN_W-1:0]        w_vppn,
   input  logic [PS_W-1:0]          w_ps,
   input  logic [ASID_W-1:0]        w_asid,
   input  logic                     w_g,
   input  logic [PPN_W-1:0]         w_ppn0,
   input  logic [PLV_W-1:0]         w_plv0,
   input  logic [MAT_W-1:0]         w_mat0,
   input  logic                     w_d0,
   input  logic                     w_v0,
   input  logic [PPN_W-1:0]         w_ppn1,
   input  logic [PLV_W-1:0]         w_plv1,
   input  logic [MAT_W-1:0]         w_mat1,
   input  logic                     w_d1,
   input  logic                     w_v1,
   output logic [IW-1:0]            fill_index,
   input  logic                     r_req,
   input  logic [IW-1:0]            r_index,
   output logic                     r_valid,
   output logic                     r_e,
   output logic [VPPN_W-1:0]        r_vppn,
   output logic [PS_W-1:0]          r_ps,
   output logic [ASID_W-1:0]        r_asid,
   output logic                     r_g,
   output logic [PPN_W-1:0]         r_ppn0,
   output logic [PLV_W-1:0]         r_plv0,
   output logic [MAT_W-1:0]         r_mat0,
   output logic                     r_d0,
   output logic                     r_v0,
   output logic [PPN_W-1:0]         r_ppn1,
   output logic [PLV_W-1:0]         r_plv1,
   output logic [MAT_W-1:0]         r_mat1,
   output logic                     r_d1,
   output logic                     r_v1
);

   logic [TLBNUM-1:0] e_q;
   tlb_entry_t        ent_q [TLBNUM];
   logic [IW-1:0]     fill_q;

   logic              wr_en;
   logic [IW-1:0]     wr_tgt;
   tlb_entry_t        w_ent;
   logic              inv_ok;
   logic [TLBNUM-1:0] inv_match;

   // invtlb wins over a simultaneous write; the write is discarded.
   assign wr_en      = we & ~inv_valid;
   assign wr_tgt     = w_fill ? fill_q : w_index;
   assign inv_ok     = inv_valid & (inv_op <= INV_GA_VA);
   assign fill_index = fill_q;

   always_comb begin
      w_ent           = '0;
      w_ent.vppn      = w_vppn;
      w_ent.ps4mb     = (w_ps == PS_4MB);
      w_ent.asid      = w_asid;
      w_ent.g         = w_g;
      w_ent.pg[0].ppn = w_ppn0;
      w_ent.pg[0].plv = w_plv0;
      w_ent.pg[0].mat = w_mat0;
      w_ent.pg[0].d   = w_d0;
      w_ent.pg[0].v   = w_v0;
      w_ent.pg[1].ppn = w_ppn1;
      w_ent.pg[1].plv = w_plv1;
      w_ent.pg[1].mat = w_mat1;
      w_ent.pg[1].d   = w_d1;
      w_ent.pg[1].v   = w_v1;
   end

   always_comb begin
      inv_match = '0;
      for (int i = 0; i < int'(TLBNUM); i++) begin
         case (inv_op)
            INV_ALL0, INV_ALL1: inv_match[i] = 1'b1;
            INV_GLB:            inv_match[i] = ent_q[i].g;
            INV_NGLB:           inv_match[i] = ~ent_q[i].g;
            INV_ASID:           inv_match[i] = ~ent_q[i].g & (ent_q[i].asid == inv_asid);
            INV_ASID_VA:        inv_match[i] = ~ent_q[i].g & (ent_q[i].asid == inv_asid) &
                                               va_hit(ent_q[i].vppn, ent_q[i].ps4mb, inv_vppn);
            INV_GA_VA:          inv_match[i] = (ent_q[i].g | (ent_q[i].asid == inv_asid)) &
                                               va_hit(ent_q[i].vppn, ent_q[i].ps4mb, inv_vppn);
            default:            inv_match[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) ent_q[wr_tgt] <= w_ent;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q     <= '0;
         fill_q  <= '0;
         inv_err <= 1'b0;
      end else begin
         if (wr_en) e_q[wr_tgt] <= w_e;
         else if (inv_ok) e_q <= e_q & ~inv_match;
         // TLBNUM is a power of two, so the natural wrap is the modulo.
         if (wr_en && w_fill) fill_q <= fill_q + 1'b1;
         inv_err <= inv_valid & (inv_op > INV_GA_VA);
      end
   end

   logic [TLBNUM-1:0] hit [NSPORT];

   for (genvar k = 0; k < NSPORT; k++) begin : g_port
      for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
         tlb_match_cell u_cell (
            .e        (e_q[i]),
            .ent_vppn (ent_q[i].vppn),
            .ps4mb    (ent_q[i].ps4mb),
            .ent_asid (ent_q[i].asid),
            .g        (ent_q[i].g),
            .vppn     (s_vppn[k*VPPN_W +: VPPN_W]),
            .asid     (s_asid[k*ASID_W +: ASID_W]),
            .hit      (hit[k][i])
         );
      end
   end

   logic [NSPORT-1:0] c_found, c_multi, c_big, c_odd;
   logic [IW-1:0]     c_idx [NSPORT];
   tlb_page_t         c_pg  [NSPORT];

   always_comb begin
      for (int k = 0; k < int'(NSPORT); k++) begin
         c_idx[k] = '0;
         for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
            if (hit[k][i]) c_idx[k] = IW'(i);
         end
         c_found[k] = |hit[k];
         c_multi[k] = |(hit[k] & (hit[k] - TLBNUM'(1)));
         c_big[k]   = ent_q[c_idx[k]].ps4mb;
         c_odd[k]   = c_big[k] ? s_vppn[k*VPPN_W + 9] : s_va_bit12[k];
         c_pg[k]    = ent_q[c_idx[k]].pg[c_odd[k]];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_valid <= '0;
         s_found <= '0;
         s_multi <= '0;
         s_index <= '0;
         s_ppn   <= '0;
         s_ps    <= '0;
         s_plv   <= '0;
         s_mat   <= '0;
         s_d     <= '0;
         s_v     <= '0;
      end else begin
         s_valid <= s_req;
         for (int k = 0; k < int'(NSPORT); k++) begin
            if (s_req[k]) begin
               s_found[k]                <= c_found[k];
               s_multi[k]                <= c_multi[k];
               s_index[k*IW +: IW]       <= c_idx[k];
               s_ppn[k*PPN_W +: PPN_W]   <= c_found[k] ? c_pg[k].ppn : '0;
               s_plv[k*PLV_W +: PLV_W]   <= c_found[k] ? c_pg[k].plv : '0;
               s_mat[k*MAT_W +: MAT_W]   <= c_found[k] ? c_pg[k].mat : '0;
               s_d[k]                    <= c_found[k] & c_pg[k].d;
               s_v[k]                    <= c_found[k] & c_pg[k].v;
               s_ps[k*PS_W +: PS_W]      <= !c_found[k] ? '0 : (c_big[k] ? PS_4MB : PS_4KB);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_e     <= 1'b0;
         r_vppn  <= '0;
         r_ps    <= '0;
         r_asid  <= '0;
         r_g     <= 1'b0;
         r_ppn0  <= '0;
         r_plv0  <= '0;
         r_mat0  <= '0;
         r_d0    <= 1'b0;
         r_v0    <= 1'b0;
         r_ppn1  <= '0;
         r_plv1  <= '0;
         r_mat1  <= '0;
         r_d1    <= 1'b0;
         r_v1    <= 1'b0;
      end else begin
         r_valid <= r_req;
         if (r_req) begin
            r_e    <= e_q[r_index];
            r_vppn <= ent_q[r_index].vppn;
            r_ps   <= ent_q[r_index].ps4mb ? PS_4MB : PS_4KB;
            r_asid <= ent_q[r_index].asid;
            r_g    <= ent_q[r_index].g;
            r_ppn0 <= ent_q[r_index].pg[0].ppn;
            r_plv0 <= ent_q[r_index].pg[0].plv;
            r_mat0 <= ent_q[r_index].pg[0].mat;
            r_d0   <= ent_q[r_index].pg[0].d;
            r_v0   <= ent_q[r_index].pg[0].v;
            r_ppn1 <= ent_q[r_index].pg[1].ppn;
            r_plv1 <= ent_q[r_index].pg[1].plv;
            r_mat1 <= ent_q[r_index].pg[1].mat;
            r_d1   <= ent_q[r_index].pg[1].d;
            r_v1   <= ent_q[r_index].pg[1].v;
         end
      end
   end

endmodule

// File: tb/tb_tlb_mport.sv
// Directed plus randomized check of tlb_mport against an entry-list reference model.
module tb_tlb_mport;

   localparam int N  = 16;
   localparam int NS = 2;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [NS-1:0]    s_req, s_va_bit12, s_valid, s_found, s_multi, s_d, s_v;
   logic [NS*19-1:0] s_vppn;
   logic [NS*10-1:0] s_asid;
   logic [NS*IW-1:0] s_index;
   logic [NS*20-1:0] s_ppn;
   logic [NS*6-1:0]  s_ps;
   logic [NS*2-1:0]  s_plv, s_mat;
   logic             inv_valid, inv_err;
   logic [4:0]       inv_op;
   logic [9:0]       inv_asid;
   logic [18:0]      inv_vppn;
   logic             we, w_fill, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [IW-1:0]    w_index, fill_index, r_index;
   logic [18:0]      w_vppn, r_vppn;
   logic [5:0]       w_ps, r_ps;
   logic [9:0]       w_asid, r_asid;
   logic [19:0]      w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [1:0]       w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
   logic             r_req, r_valid, r_e, r_g, r_d0, r_v0, r_d1, r_v1;

   tlb_mport #(.TLBNUM(N), .NSPORT(NS)) dut (
      .clk(clk), .resetn(resetn),
      .s_req(s_req), .s_vppn(s_vppn), .s_asid(s_asid), .s_va_bit12(s_va_bit12),
      .s_valid(s_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
      .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
      .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .inv_err(inv_err),
      .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
      .w_asid(w_asid), .w_g(w_g),
      .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
      .fill_index(fill_index),
      .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_e(r_e), .r_vppn(r_vppn),
      .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
      .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
   );

   // Reference model: one record per entry, attributes {plv,mat,d,v} per half-page.
   bit        m_e    [N];
   bit [18:0] m_vppn [N];
   bit        m_big  [N];
   bit [9:0]  m_asid [N];
   bit        m_g    [N];
   bit [19:0] m_ppn  [N][2];
   bit [5:0]  m_att  [N][2];
   int        m_fill;

   bit        e_found [NS], e_multi [NS];
   int        e_idx [NS];
   bit [19:0] e_ppn [NS];
   bit [5:0]  e_ps [NS], e_att [NS];
   bit        er_e, er_g;
   bit [18:0] er_vppn;
   bit [5:0]  er_ps, er_att0, er_att1;
   bit [9:0]  er_asid;
   bit [19:0] er_ppn0, er_ppn1;

   int vecs = 0;
   int miss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_match(int i, logic [18:0] vp, logic [9:0] as);
      bit va;
      if (!m_e[i]) return 1'b0;
      va = m_big[i] ? ((vp >> 10) == (m_vppn[i] >> 10)) : (vp == m_vppn[i]);
      return va && (m_g[i] || as == m_asid[i]);
   endfunction

   function automatic bit m_inv_hit(int i, int op, logic [9:0] as, logic [18:0] vp);
      bit va = m_big[i] ? ((vp >> 10) == (m_vppn[i] >> 10)) : (vp == m_vppn[i]);
      bit am = (as == m_asid[i]);
      case (op)
         0, 1:    return 1'b1;
         2:       return m_g[i];
         3:       return !m_g[i];
         4:       return !m_g[i] && am;
         5:       return !m_g[i] && am && va;
         6:       return (m_g[i] || am) && va;
         default: return 1'b0;
      endcase
   endfunction

   task automatic predict_search(input int k);
      logic [18:0] vp = s_vppn[k*19 +: 19];
      int cnt = 0, first = 0, odd;
      for (int i = 0; i < N; i++) if (m_match(i, vp, s_asid[k*10 +: 10])) begin
         if (cnt == 0) first = i;
         cnt++;
      end
      e_found[k] = (cnt > 0);
      e_multi[k] = (cnt > 1);
      e_idx[k]   = first;
      odd = m_big[first] ? int'(vp[9]) : int'(s_va_bit12[k]);
      e_ppn[k] = (cnt > 0) ? m_ppn[first][odd] : 20'h0;
      e_att[k] = (cnt > 0) ? m_att[first][odd] : 6'h0;
      e_ps[k]  = (cnt == 0) ? 6'h00 : (m_big[first] ? 6'h16 : 6'h0c);
   endtask

   task automatic model_update();
      int tgt;
      if (inv_valid) begin
         for (int i = 0; i < N; i++) if (m_inv_hit(i, int'(inv_op), inv_asid, inv_vppn)) m_e[i] = 0;
      end else if (we) begin
         tgt = w_fill ? m_fill : int'(w_index);
         m_e[tgt] = w_e; m_vppn[tgt] = w_vppn; m_big[tgt] = (w_ps == 6'h16);
         m_asid[tgt] = w_asid; m_g[tgt] = w_g;
         m_ppn[tgt][0] = w_ppn0; m_att[tgt][0] = {w_plv0, w_mat0, w_d0, w_v0};
         m_ppn[tgt][1] = w_ppn1; m_att[tgt][1] = {w_plv1, w_mat1, w_d1, w_v1};
         if (w_fill) m_fill = (m_fill + 1) % N;
      end
   endtask

   // One clock: predict from pre-edge model, clock, update model, compare, drop strobes.
   task automatic step();
      bit [NS-1:0] req_s = s_req;
      bit req_r = r_req;
      bit exp_err = inv_valid && (inv_op > 5'd6);
      int ri = int'(r_index);
      for (int k = 0; k < NS; k++) if (req_s[k]) predict_search(k);
      if (req_r) begin
         er_e = m_e[ri]; er_vppn = m_vppn[ri]; er_ps = m_big[ri] ? 6'h16 : 6'h0c;
         er_asid = m_asid[ri]; er_g = m_g[ri];
         er_ppn0 = m_ppn[ri][0]; er_att0 = m_att[ri][0];
         er_ppn1 = m_ppn[ri][1]; er_att1 = m_att[ri][1];
      end
      @(posedge clk); #1;
      model_update();
      chk("s_valid", 32'(s_valid), 32'(req_s));
      for (int k = 0; k < NS; k++) if (req_s[k]) begin
         chk($sformatf("s_found[%0d]", k), 32'(s_found[k]), 32'(e_found[k]));
         chk($sformatf("s_multi[%0d]", k), 32'(s_multi[k]), 32'(e_multi[k]));
         chk($sformatf("s_index[%0d]", k), 32'(s_index[k*IW +: IW]), 32'(e_idx[k]));
         chk($sformatf("s_ppn[%0d]", k), 32'(s_ppn[k*20 +: 20]), 32'(e_ppn[k]));
         chk($sformatf("s_ps[%0d]", k), 32'(s_ps[k*6 +: 6]), 32'(e_ps[k]));
         chk($sformatf("s_attr[%0d]", k),
             32'({s_plv[k*2 +: 2], s_mat[k*2 +: 2], s_d[k], s_v[k]}), 32'(e_att[k]));
      end
      chk("r_valid", 32'(r_valid), 32'(req_r));
      if (req_r) begin
         chk("r_e", 32'(r_e), 32'(er_e));
         chk("r_vppn", 32'(r_vppn), 32'(er_vppn));
         chk("r_ps", 32'(r_ps), 32'(er_ps));
         chk("r_asid_g", 32'({r_asid, r_g}), 32'({er_asid, er_g}));
         chk("r_page0", 32'({r_ppn0, r_plv0, r_mat0, r_d0, r_v0}), 32'({er_ppn0, er_att0}));
         chk("r_page1", 32'({r_ppn1, r_plv1, r_mat1, r_d1, r_v1}), 32'({er_ppn1, er_att1}));
      end
      chk("inv_err", 32'(inv_err), 32'(exp_err));
      chk("fill_index", 32'(fill_index), 32'(m_fill));
      s_req = '0; r_req = 1'b0; we = 1'b0; inv_valid = 1'b0;
   endtask

   task automatic set_w(input bit fill, input int idx, input bit e, input logic [18:0] vp,
                        input bit big, input logic [9:0] as, input bit g,
                        input logic [19:0] p0, input logic [19:0] p1);
      we = 1'b1; w_fill = fill; w_index = IW'(idx); w_e = e; w_vppn = vp;
      w_ps = big ? 6'h16 : (($urandom % 2 == 0) ? 6'h0c : 6'h15);
      w_asid = as; w_g = g; w_ppn0 = p0; w_ppn1 = p1;
      {w_plv0, w_mat0, w_d0, w_v0} = 6'($urandom);
      {w_plv1, w_mat1, w_d1, w_v1} = 6'($urandom);
   endtask

   task automatic set_s(input int k, input logic [18:0] vp, input logic [9:0] as, input bit b12);
      s_req[k] = 1'b1; s_vppn[k*19 +: 19] = vp; s_asid[k*10 +: 10] = as; s_va_bit12[k] = b12;
   endtask

   task automatic set_r(input int idx);
      r_req = 1'b1; r_index = IW'(idx);
   endtask

   task automatic set_inv(input int op, input logic [9:0] as, input logic [18:0] vp);
      inv_valid = 1'b1; inv_op = 5'(op); inv_asid = as; inv_vppn = vp;
   endtask

   function automatic logic [18:0] pool_vp();
      logic [8:0] hi [2];
      logic [9:0] lo [3];
      hi[0] = 9'h091; hi[1] = 9'h1a3;
      lo[0] = 10'h345; lo[1] = 10'h0f0; lo[2] = 10'h200;
      return {hi[$urandom % 2], lo[$urandom % 3]};
   endfunction

   initial begin
      resetn = 1'b0;
      s_req = '0; s_vppn = '0; s_asid = '0; s_va_bit12 = '0;
      inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
      we = 1'b0; w_fill = 1'b0; w_index = '0; w_e = 1'b0; w_vppn = '0; w_ps = '0;
      w_asid = '0; w_g = 1'b0; w_ppn0 = '0; w_ppn1 = '0;
      {w_plv0, w_mat0, w_d0, w_v0} = '0; {w_plv1, w_mat1, w_d1, w_v1} = '0;
      r_req = 1'b0; r_index = '0;
      m_fill = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst s_valid", 32'(s_valid), 32'h0);
      chk("rst r_valid", 32'(r_valid), 32'h0);
      chk("rst fill_index", 32'(fill_index), 32'h0);
      chk("rst inv_err", 32'(inv_err), 32'h0);
      resetn = 1'b1;

      // Empty TLB: every lookup misses.
      for (int k = 0; k < NS; k++) set_s(k, 19'($urandom), 10'($urandom), 1'($urandom));
      step();
      chk("empty found", 32'(s_found), 32'h0);

      set_w(0, 5, 1, 19'h12345, 0, 10'd3, 0, 20'hAAAAA, 20'hBBBBB);
      step();
      set_s(1, 19'h12345, 10'd3, 1);
      set_s(0, 19'h12345, 10'd4, 0);
      step();
      chk("tlbwr idx", 32'(s_index[IW +: IW]), 32'd5);
      chk("tlbwr ppn", 32'(s_ppn[20 +: 20]), 32'hBBBBB);
      chk("tlbwr ps", 32'(s_ps[6 +: 6]), 32'h0c);

      // 4MB entry plus overlapping 4KB entry, both global.
      set_w(0, 5, 1, 19'h12345, 1, 10'd3, 1, 20'hAAAAA, 20'hBBBBB); step();
      set_w(0, 9, 1, 19'h12345, 0, 10'd7, 1, 20'h11111, 20'h22222); step();
      set_s(0, 19'h12345, 10'h3ff, 1); step();
      chk("multi", 32'({s_found[0], s_multi[0]}), 32'h3);
      chk("multi idx", 32'(s_index[0 +: IW]), 32'd5);

      // Search in the same cycle as a write sees old contents.
      set_w(0, 5, 0, 19'h12345, 1, 10'd3, 1, 20'hAAAAA, 20'hBBBBB);
      set_s(0, 19'h12345, 10'h3ff, 1); step();
      chk("old data idx", 32'(s_index[0 +: IW]), 32'd5);
      set_s(0, 19'h12345, 10'h3ff, 1); step();
      chk("new data idx", 32'(s_index[0 +: IW]), 32'd9);

      // Round-robin fill across all entries; one tlbwr in the middle.
      for (int f = 0; f < N; f++) begin
         logic [18:0] vp = pool_vp();
         set_w(1, 0, 1, vp, 1'($urandom), 10'($urandom_range(1, 3)), 1'($urandom),
               20'($urandom), 20'($urandom));
         step();
         set_r(f); step();
         chk("fill target", 32'(r_vppn), 32'(vp));
         if (f == 2) begin
            set_w(0, 15, 1, pool_vp(), 0, 10'd1, 0, 20'h1, 20'h2); step();
            chk("tlbwr keeps fill", 32'(fill_index), 32'd3);
         end
      end
      chk("fill wrap", 32'(fill_index), 32'd0);

      // invtlb op4 only removes non-global entries of the given ASID.
      set_w(0, 0, 1, 19'h00100, 0, 10'd1, 0, 20'h10, 20'h11); step();
      set_w(0, 1, 1, 19'h00200, 0, 10'd2, 0, 20'h20, 20'h21); step();
      set_w(0, 2, 1, 19'h00300, 0, 10'd1, 1, 20'h30, 20'h31); step();
      set_inv(4, 10'd1, 19'h0); step();
      set_r(0); step(); chk("op4 e0", 32'(r_e), 32'd0);
      set_r(1); step(); chk("op4 e1", 32'(r_e), 32'd1);
      set_r(2); step(); chk("op4 e2", 32'(r_e), 32'd1);
      set_inv(7, 10'd2, 19'h0); step();
      chk("op7 err", 32'(inv_err), 32'd1);
      set_r(1); step(); chk("op7 keeps", 32'(r_e), 32'd1);

      // invtlb beats a simultaneous fill write.
      set_w(1, 0, 1, 19'h7abcd, 0, 10'd5, 0, 20'h5, 20'h6);
      set_inv(2, 10'd0, 19'h0); step();
      chk("dropped fill", 32'(fill_index), 32'd0);
      set_s(0, 19'h7abcd, 10'd5, 0); step();
      chk("dropped write", 32'(s_found[0]), 32'd0);

      for (int n = 0; n < 300; n++) begin
         int r = int'($urandom % 8);
         if (r <= 2 || r == 4)
            set_w(1'($urandom), int'($urandom % N), ($urandom % 4) != 0, pool_vp(),
                  1'($urandom), 10'($urandom_range(1, 3)), 1'($urandom),
                  20'($urandom), 20'($urandom));
         if (r == 3 || r == 4)
            set_inv(int'($urandom % 8), 10'($urandom_range(1, 3)), pool_vp());
         for (int k = 0; k < NS; k++)
            if ($urandom % 10 < 7) set_s(k, pool_vp(), 10'($urandom_range(1, 3)), 1'($urandom));
         if ($urandom % 2 == 1) set_r(int'($urandom % N));
         step();
      end

      // Reset in the middle of a lookup.
      set_s(0, pool_vp(), 10'd1, 0); set_r(3);
      @(posedge clk); #1;
      resetn = 1'b0; #1;
      chk("rst mid s_valid", 32'(s_valid), 32'h0);
      chk("rst mid r_valid", 32'(r_valid), 32'h0);
      s_req = '0; r_req = 1'b0;
      for (int i = 0; i < N; i++) m_e[i] = 0;
      m_fill = 0;
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int k = 0; k < NS; k++) set_s(k, pool_vp(), 10'($urandom_range(1, 3)), 1'($urandom));
      step();
      chk("post rst found", 32'(s_found), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
